alpha_recursion: RTL and testbench
==================================

# alpha_recursion

Self-contained forward (alpha) recursion engine for the max-product turbo decoder. It holds the alpha state vector internally and advances it one trellis step per accepted branch-metric set. The previous generation took `previousAlpha` as an input; this block adds:
- frame start/end control
- start-state initialisation
- max-normalisation
- valid/ready backpressure
- multiple time-interleaved channels

It sits between the branch-metric unit and the alpha memory / LLR stage. Arithmetic is fixed-point two's-complement.

## Interface
- `BITS`, 16, signed metric width.
- `STATES`, 4, trellis states; power of two.
- `CHANNELS`, 2, independent alpha contexts; ≥1.
- `CH_BITS`, $clog2(CHANNELS) (min 1), channel index width.
- `INIT_KNOWN`, 1, start-state initialisation mode.
  - 1: the start state is known (state 0).
  - 0: uniform start.
- `clk`, input, 1: clock; everything is on the rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `trellis`, interface `trellis_if`: supplies `OUTPUT_SYMBOLS` and the predecessor tables `prev_state[s][u]` and `prev_out[s][u]`, for u ∈ {0,1}.
- `in_valid`, input, 1: branch-metric set present.
- `in_ready`, output, 1: block accepts the input this cycle.
- `in_first`, input, 1: first trellis step of a frame on `in_ch`.
- `in_last`, input, 1: last trellis step of a frame.
- `in_ch`, input, CH_BITS: channel index.
- `branch_metric[OUTPUT_SYMBOLS]`, input, BITS each: signed branch metrics.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: downstream accepts the result.
- `out_last`, output, 1: `in_last` of the producing step.
- `out_ch`, output, CH_BITS: channel of the result.
- `AlphaMetric[STATES]`, output, BITS each: alpha vector after the step.

## Operation
- **Init vector:**
  - INIT_KNOWN=1: state 0 = 0; all other states = NEG = −2^(BITS−2).
  - INIT_KNOWN=0: all states = 0.
- **Previous vector:** if `in_first`=1, the init vector; otherwise the channel register `alpha_q[in_ch]`.
- **Add-compare-select:** for each state s, a(s) = max over u of sat(prev[prev_state[s][u]] + branch_metric[prev_out[s][u]]).
  - The add is done at BITS+1 bits, then saturated to [−2^(BITS−1), 2^(BITS−1)−1].
  - The compare is signed. On a tie, take u=0.
- **Normalisation** (when enabled): m = max over s of a(s); result(s) = a(s) − m. Results are therefore ≤ 0, and state(s) at the max are exactly 0.
  - The subtraction is saturated at −2^(BITS−1).
- **On accept** (`in_valid && in_ready`):
  - The result is written to `alpha_q[in_ch]`.
  - The result is also registered to `AlphaMetric`, with `out_ch`, `out_last` and `out_valid`=1.
- **Handshake:**
  - `in_ready` = !`out_valid` || `out_ready` (combinational).
  - Outputs are held stable while `out_valid && !out_ready`.
  - `out_valid` deasserts after a transfer with no new accept.
- **Channels:**
  - Each channel's recursion is independent; channels may interleave arbitrarily cycle-by-cycle.
  - `in_first` on a channel with an unfinished frame restarts that channel. No error is raised.
- A step without `in_first` on a channel never used since reset uses the init vector, because reset loads it.
- `in_ch` ≥ CHANNELS: the input is accepted, but the result is not written to any register and `out_valid` is not asserted. The input is dropped.

## Timing
- **Latency:** 1 cycle from accept to `out_valid`.
- **Throughput:** one step per cycle, including the same channel back-to-back. The recursion loop is ACS + normalise, combinational in one cycle.
- Simultaneous output transfer and new accept in the same cycle is supported with no bubble.
- **Reset values:**
  - `out_valid`=0, `out_last`=0, `out_ch`=0
  - `AlphaMetric`=all 0
  - `alpha_q[c]`=init vector for every channel
  - `in_ready`=1 after reset
- Reset asserted mid-frame discards the in-flight output and all channel state. It takes effect immediately (asynchronous).

## Configuration
- `ALPHA_NORM_EN` defined: max-normalisation is applied as described in Operation.
- `ALPHA_NORM_EN` undefined: the max tree and subtraction are removed, and the saturated ACS values are output and stored directly. Saturation behaviour is unchanged.

## Structure
- Package `turbo_mp_pkg` holds:
  - typedef `metric_t` (logic signed [BITS−1:0])
  - function `sat_add` (BITS+1 → BITS clamp)
  - function `smax`
  - function `init_vector(INIT_KNOWN)`
- One sub-module, `alpha_acs_norm`: combinational ACS plus optional normalisation for a single vector. It is reused by the beta recursion.
- Channel registers, handshake and output registers live in `alpha_recursion`.

## Test plan
Configuration for all scenarios: STATES=4, POLY={5,7}, RECURSIVE=7, BITS=16, CHANNELS=2.
1. INIT_KNOWN=0, norm on, `in_first`=1, bm={5,5,5,5} → after 1 cycle, `AlphaMetric`={0,0,0,0}, `out_valid`=1.
2. INIT_KNOWN=1, norm on, `in_first`=1, bm={3,3,3,3} → the two successors of state 0 = 0; the other two states = −16384.
3. Norm off (`ALPHA_NORM_EN` undefined), uniform init, bm=32767 on all symbols for 3 steps → alpha 32767 from step 1 onward, never wraps negative.
4. `out_ready` held low 3 cycles with `in_valid`=1 → `in_ready`=0, outputs stable; on release, 1 transfer per cycle resumes.
5. Alternate ch0/ch1 with different bm each cycle, `in_last` on ch1 step 4 → each channel matches a golden model run per channel; `out_last`=1 and `out_ch`=1 on that result.
6. Assert `reset` mid-frame → `out_valid`=0 immediately; the next step without `in_first` uses the init vector.

Source files
------------

// File: rtl/turbo_mp_pkg.sv
// turbo_mp_pkg: shared types and arithmetic helpers for the max-product turbo decoder.
//   metric_t     signed fixed-point path metric (METRIC_BITS wide)
//   metric_vec_t one metric per trellis state
//   bm_vec_t     one branch metric per output symbol
//   sat_add      (BITS+1)-bit add clamped back to BITS
//   sat_sub      (BITS+1)-bit subtract clamped back to BITS
//   smax         signed max, ties keep the first operand
//   init_vector  frame start vector (known state 0 or uniform)
package turbo_mp_pkg;

    localparam int unsigned METRIC_BITS = 16;
    localparam int unsigned NUM_STATES  = 4;
    localparam int unsigned NUM_SYMBOLS = 4;
    localparam int unsigned STATE_BITS  = $clog2(NUM_STATES);
    localparam int unsigned SYM_BITS    = $clog2(NUM_SYMBOLS);

    typedef logic signed [METRIC_BITS-1:0] metric_t;
    typedef metric_t [NUM_STATES-1:0]      metric_vec_t;
    typedef metric_t [NUM_SYMBOLS-1:0]     bm_vec_t;
    typedef logic [STATE_BITS-1:0]         state_idx_t;
    typedef logic [SYM_BITS-1:0]           sym_idx_t;
    typedef state_idx_t [NUM_STATES-1:0][1:0] prev_state_tab_t;
    typedef sym_idx_t [NUM_STATES-1:0][1:0]   prev_out_tab_t;

    localparam metric_t METRIC_MAX = metric_t'({1'b0, {(METRIC_BITS-1){1'b1}}});
    localparam metric_t METRIC_MIN = metric_t'({1'b1, {(METRIC_BITS-1){1'b0}}});
    // "Impossible" start-state metric; far enough from MIN that a few adds cannot wrap.
    localparam metric_t METRIC_NEG = metric_t'({2'b11, {(METRIC_BITS-2){1'b0}}});

    function automatic metric_t sat_add(metric_t a, metric_t b);
        logic signed [METRIC_BITS:0] sum;
        sum = {a[METRIC_BITS-1], a} + {b[METRIC_BITS-1], b};
        // Top two bits differ only when the result left the BITS-wide range.
        if (sum[METRIC_BITS] != sum[METRIC_BITS-1]) begin
            return sum[METRIC_BITS] ? METRIC_MIN : METRIC_MAX;
        end
        return metric_t'(sum[METRIC_BITS-1:0]);
    endfunction

    function automatic metric_t sat_sub(metric_t a, metric_t b);
        logic signed [METRIC_BITS:0] diff;
        diff = {a[METRIC_BITS-1], a} - {b[METRIC_BITS-1], b};
        if (diff[METRIC_BITS] != diff[METRIC_BITS-1]) begin
            return diff[METRIC_BITS] ? METRIC_MIN : METRIC_MAX;
        end
        return metric_t'(diff[METRIC_BITS-1:0]);
    endfunction

    function automatic metric_t smax(metric_t a, metric_t b);
        return (b > a) ? b : a;
    endfunction

    function automatic metric_vec_t init_vector(bit init_known);
        metric_vec_t v;
        for (int unsigned s = 0; s < NUM_STATES; s++) begin
            v[s] = (init_known && (s != 0)) ? METRIC_NEG : '0;
        end
        return v;
    endfunction

endpackage

// File: rtl/alpha_recursion_if.sv
// alpha_recursion_if: streaming handshake between branch-metric unit, alpha engine and
// the alpha memory / LLR stage.
//   in_valid/in_ready    branch-metric set handshake (in_first, in_last, in_ch, branch_metric)
//   out_valid/out_ready  alpha result handshake (out_last, out_ch, AlphaMetric)
// Modports: master (upstream producer + downstream consumer), slave (alpha engine).
interface alpha_recursion_if import turbo_mp_pkg::*; #(
    parameter int unsigned CH_BITS = 1
) ();

    logic               in_valid;
    logic               in_ready;
    logic               in_first;
    logic               in_last;
    logic [CH_BITS-1:0] in_ch;
    bm_vec_t            branch_metric;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic [CH_BITS-1:0] out_ch;
    metric_vec_t        AlphaMetric;

    modport master (
        output in_valid, in_first, in_last, in_ch, branch_metric, out_ready,
        input  in_ready, out_valid, out_last, out_ch, AlphaMetric
    );

    modport slave (
        input  in_valid, in_first, in_last, in_ch, branch_metric, out_ready,
        output in_ready, out_valid, out_last, out_ch, AlphaMetric
    );

endinterface

// File: rtl/trellis_if.sv
// trellis_if: static trellis description for the ACS stage.
//   prev_state[s][u]  predecessor of state s reached with input bit u
//   prev_out[s][u]    output symbol index labelling that branch
// Modports: source (table provider), sink (recursion engine).
interface trellis_if import turbo_mp_pkg::*; ();

    localparam int unsigned OUTPUT_SYMBOLS = NUM_SYMBOLS;

    prev_state_tab_t                                          prev_state;
    logic [NUM_STATES-1:0][1:0][$clog2(OUTPUT_SYMBOLS)-1:0] prev_out;

    modport source (output prev_state, output prev_out);
    modport sink   (input prev_state, input prev_out);

endinterface

// File: rtl/alpha_acs_norm.sv
// alpha_acs_norm: combinational add-compare-select for one metric vector, optionally
// followed by max-normalisation. Shared with the beta recursion.
//   prev_alpha     previous metric vector
//   branch_metric  branch metric per output symbol
//   prev_state     predecessor table [state][input bit]
//   prev_out       branch symbol table [state][input bit]
//   alpha          new metric vector
// Build option: ALPHA_NORM_EN -- subtract the vector maximum (saturating) from every state.
module alpha_acs_norm import turbo_mp_pkg::*; (
    input  metric_vec_t     prev_alpha,
    input  bm_vec_t         branch_metric,
    input  prev_state_tab_t prev_state,
    input  prev_out_tab_t   prev_out,
    output metric_vec_t     alpha
);

    metric_vec_t acs;

    always_comb begin
        acs = '0;
        for (int s = 0; s < NUM_STATES; s++) begin
            // smax keeps its first argument on a tie, so u=0 wins.
            acs[s] = smax(sat_add(prev_alpha[prev_state[s][0]], branch_metric[prev_out[s][0]]),
                          sat_add(prev_alpha[prev_state[s][1]], branch_metric[prev_out[s][1]]));
        end
    end

`ifdef ALPHA_NORM_EN
    metric_t acs_max;

    always_comb begin
        acs_max = acs[0];
        for (int s = 1; s < NUM_STATES; s++) begin
            acs_max = smax(acs_max, acs[s]);
        end
        alpha = '0;
        for (int s = 0; s < NUM_STATES; s++) begin
            alpha[s] = sat_sub(acs[s], acs_max);
        end
    end
`else
    assign alpha = acs;
`endif

endmodule

// File: rtl/alpha_recursion.sv
// alpha_recursion: multi-channel forward (alpha) recursion engine for the max-product
// turbo decoder. Holds one alpha vector per channel and advances it one trellis step per
// accepted branch-metric set; the result is registered with a 1-cycle latency.
//   clk      clock, rising edge
//   reset    asynchronous, active-high
//   trellis  trellis_if.sink: predecessor / branch-symbol tables
//   bus      alpha_recursion_if.slave: input and output valid/ready streams
// Build option: ALPHA_NORM_EN -- enable max-normalisation inside alpha_acs_norm.
module alpha_recursion import turbo_mp_pkg::*; #(
    parameter int unsigned BITS       = METRIC_BITS,
    parameter int unsigned STATES     = NUM_STATES,
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned CH_BITS    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    parameter bit          INIT_KNOWN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    trellis_if.sink           trellis,
    alpha_recursion_if.slave  bus
);

    localparam metric_vec_t INIT_VEC = init_vector(INIT_KNOWN);

    metric_vec_t alpha_q [CHANNELS];
    metric_vec_t prev_alpha;
    metric_vec_t next_alpha;
    logic        ch_ok;
    logic        accept;
    logic        write_en;

    logic                         out_valid_q, out_valid_d;
    logic                         out_last_q, out_last_d;
    logic [CH_BITS-1:0]           out_ch_q, out_ch_d;
    logic [STATES-1:0][BITS-1:0]  alpha_out_q, alpha_out_d;

    assign ch_ok        = (32'(bus.in_ch) < CHANNELS);
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    // Out-of-range channels are consumed but leave no trace.
    assign write_en     = accept && ch_ok;

    always_comb begin
        prev_alpha = INIT_VEC;
        if (!bus.in_first && ch_ok) begin
            prev_alpha = alpha_q[bus.in_ch];
        end
    end

    alpha_acs_norm u_acs_norm (
        .prev_alpha    (prev_alpha),
        .branch_metric (bus.branch_metric),
        .prev_state    (trellis.prev_state),
        .prev_out      (trellis.prev_out),
        .alpha         (next_alpha)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_ch_d    = out_ch_q;
        alpha_out_d = alpha_out_q;
        if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (write_en) begin
            out_valid_d = 1'b1;
            out_last_d  = bus.in_last;
            out_ch_d    = bus.in_ch;
            alpha_out_d = next_alpha;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
            alpha_out_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_ch_q    <= out_ch_d;
            alpha_out_q <= alpha_out_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                alpha_q[c] <= INIT_VEC;
            end
        end else if (write_en) begin
            alpha_q[bus.in_ch] <= next_alpha;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_last    = out_last_q;
    assign bus.out_ch      = out_ch_q;
    assign bus.AlphaMetric = alpha_out_q;

endmodule

// File: tb/tb_alpha_recursion.sv
// tb_alpha_recursion: two DUTs (known-start and uniform-start) share one stimulus stream;
// results are compared with a trellis-level reference built from the RSC encoder
// equations (feedback 7, feedforward 5) using plain integer arithmetic.
module tb_alpha_recursion;
    import turbo_mp_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_first, in_last, out_ready;
    logic [0:0] in_ch;
    bm_vec_t    bm;
    int         cur_bm [4];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    trellis_if tr ();
    alpha_recursion_if #(.CH_BITS(1)) ifk ();
    alpha_recursion_if #(.CH_BITS(1)) ifu ();

    assign ifk.in_valid = in_valid;       assign ifu.in_valid = in_valid;
    assign ifk.in_first = in_first;       assign ifu.in_first = in_first;
    assign ifk.in_last  = in_last;        assign ifu.in_last  = in_last;
    assign ifk.in_ch    = in_ch;          assign ifu.in_ch    = in_ch;
    assign ifk.branch_metric = bm;        assign ifu.branch_metric = bm;
    assign ifk.out_ready = out_ready;     assign ifu.out_ready = out_ready;

    alpha_recursion #(.CHANNELS(2), .CH_BITS(1), .INIT_KNOWN(1'b1)) u_dut_known (
        .clk(clk), .reset(reset), .trellis(tr), .bus(ifk)
    );
    alpha_recursion #(.CHANNELS(2), .CH_BITS(1), .INIT_KNOWN(1'b0)) u_dut_uniform (
        .clk(clk), .reset(reset), .trellis(tr), .bus(ifu)
    );

    // Trellis tables derived from the encoder: state = {r1, r2}, symbol = {u, parity}.
    initial begin
        for (int s = 0; s < 4; s++) begin
            for (int u = 0; u < 2; u++) begin
                int r1, r2, a, p;
                r1 = s >> 1; r2 = s & 1;
                a = u ^ r1 ^ r2; p = a ^ r2;
                tr.prev_state[a * 2 + r1][u] = 2'(s);
                tr.prev_out[a * 2 + r1][u]   = 2'(u * 2 + p);
            end
        end
    end

    typedef struct packed {
        metric_vec_t vec;
        logic        ch;
        logic        last;
    } exp_t;

    exp_t qk[$];
    exp_t qu[$];
    int   mdl [2][2][4];  // [kind: 0 uniform, 1 known][channel][state]

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int clampi(int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic int init_val(int kind, int s);
        return (kind == 1 && s != 0) ? -16384 : 0;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < 2; c++)
                for (int s = 0; s < 4; s++) mdl[k][c][s] = init_val(k, s);
    endfunction

    function automatic metric_vec_t model_step(int kind, bit first, int ch);
        int prev [4];
        int nxt [4];
        int m;
        metric_vec_t v;
        for (int s = 0; s < 4; s++) begin
            prev[s] = first ? init_val(kind, s) : mdl[kind][ch][s];
            nxt[s]  = -100000;
        end
        for (int s = 0; s < 4; s++) begin
            for (int u = 0; u < 2; u++) begin
                int r1, r2, a, p, ns, cand;
                r1 = s >> 1; r2 = s & 1;
                a = u ^ r1 ^ r2; p = a ^ r2;
                ns = a * 2 + r1;
                cand = clampi(prev[s] + cur_bm[u * 2 + p]);
                if (cand > nxt[ns]) nxt[ns] = cand;
            end
        end
`ifdef ALPHA_NORM_EN
        m = nxt[0];
        for (int s = 1; s < 4; s++) if (nxt[s] > m) m = nxt[s];
        for (int s = 0; s < 4; s++) nxt[s] = clampi(nxt[s] - m);
`else
        m = 0;
`endif
        for (int s = 0; s < 4; s++) begin
            mdl[kind][ch][s] = nxt[s];
            v[s] = 16'(nxt[s]);
        end
        return v;
    endfunction

    function automatic int rand_bm();
        if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 400)) - 200;
        return int'($signed(16'($urandom)));
    endfunction

    // One clock: drive at the falling edge, check 1 time unit later, advance the model.
    task automatic step(input bit v, input bit f, input bit l, input int ch, input bit ordy);
        bit exp_valid;
        exp_t e;
        @(negedge clk);
        in_valid = v; in_first = f; in_last = l; in_ch = 1'(ch); out_ready = ordy;
        for (int i = 0; i < 4; i++) bm[i] = 16'(cur_bm[i]);
        #1;
        exp_valid = (qk.size() != 0);
        check_eq("out_valid_k", ifk.out_valid, exp_valid);
        check_eq("out_valid_u", ifu.out_valid, exp_valid);
        check_eq("in_ready_k", ifk.in_ready, !exp_valid || ordy);
        check_eq("in_ready_u", ifu.in_ready, !exp_valid || ordy);
        if (exp_valid) begin
            check_eq("alpha_k", ifk.AlphaMetric, qk[0].vec);
            check_eq("alpha_u", ifu.AlphaMetric, qu[0].vec);
            check_eq("out_ch_k", ifk.out_ch, qk[0].ch);
            check_eq("out_last_k", ifk.out_last, qk[0].last);
            check_eq("out_ch_u", ifu.out_ch, qu[0].ch);
            check_eq("out_last_u", ifu.out_last, qu[0].last);
            if (ordy) begin
                void'(qk.pop_front());
                void'(qu.pop_front());
            end
        end
        if (v && (!exp_valid || ordy)) begin
            e.ch = 1'(ch); e.last = l;
            e.vec = model_step(1, f, ch); qk.push_back(e);
            e.vec = model_step(0, f, ch); qu.push_back(e);
        end
    endtask

    task automatic set_bm(input int a, input int b, input int c, input int d);
        cur_bm[0] = a; cur_bm[1] = b; cur_bm[2] = c; cur_bm[3] = d;
    endtask

    task automatic check_reset_state();
        check_eq("rst_out_valid_k", ifk.out_valid, 1'b0);
        check_eq("rst_out_valid_u", ifu.out_valid, 1'b0);
        check_eq("rst_out_ch_k", ifk.out_ch, 1'b0);
        check_eq("rst_out_last_k", ifk.out_last, 1'b0);
        check_eq("rst_alpha_k", ifk.AlphaMetric, 64'h0);
        check_eq("rst_alpha_u", ifu.AlphaMetric, 64'h0);
        check_eq("rst_in_ready_k", ifk.in_ready, 1'b1);
    endtask

    logic [63:0] exp_known_bm3;
    logic [63:0] exp_uni_bm5;
    logic [63:0] exp_uni_sat;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef ALPHA_NORM_EN
        exp_known_bm3 = 64'hC000_0000_C000_0000;
        exp_uni_bm5   = 64'h0;
        exp_uni_sat   = 64'h0;
`else
        exp_known_bm3 = 64'hC003_0003_C003_0003;
        exp_uni_bm5   = 64'h0005_0005_0005_0005;
        exp_uni_sat   = 64'h7FFF_7FFF_7FFF_7FFF;
`endif
        reset = 1'b1;
        in_valid = 0; in_first = 0; in_last = 0; in_ch = 0; out_ready = 0; bm = '0;
        set_bm(0, 0, 0, 0);
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check_reset_state();
        @(negedge clk);
        reset = 1'b0;

        // Uniform start, bm 5, then known start, bm 3.
        set_bm(5, 5, 5, 5);
        step(1, 1, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check_eq("uniform_bm5", ifu.AlphaMetric, exp_uni_bm5);
        set_bm(3, 3, 3, 3);
        step(1, 1, 0, 1, 1);
        step(0, 0, 0, 0, 1);
        check_eq("known_bm3", ifk.AlphaMetric, exp_known_bm3);

        // Saturating branch metrics on one channel.
        set_bm(32767, 32767, 32767, 32767);
        for (int i = 0; i < 3; i++) begin
            step(1, i == 0, 0, 1, 1);
            step(0, 0, 0, 1, 1);
            check_eq("uniform_sat", ifu.AlphaMetric, exp_uni_sat);
        end

        // Downstream stall for three cycles, then back-to-back transfers.
        set_bm(10, -20, 30, -40);
        step(1, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0);
            check_eq("stall_in_ready", ifk.in_ready, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            set_bm(rand_bm(), rand_bm(), rand_bm(), rand_bm());
            step(1, 0, 0, 0, 1);
            check_eq("resume_valid", ifk.out_valid, 1'b1);
        end

        // Interleaved channels, last on channel 1 step 4.
        for (int i = 0; i < 8; i++) begin
            set_bm(rand_bm(), rand_bm(), rand_bm(), rand_bm());
            step(1, i < 2, i == 7, i % 2, 1);
        end
        step(0, 0, 0, 0, 0);
        check_eq("interleave_last", ifk.out_last, 1'b1);
        check_eq("interleave_ch", ifk.out_ch, 1'b1);
        step(0, 0, 0, 0, 1);

        // Reset mid-frame with a stalled result in flight.
        set_bm(7, 1, -3, 2);
        step(1, 1, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("midrst_valid_k", ifk.out_valid, 1'b0);
        check_eq("midrst_valid_u", ifu.out_valid, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        in_valid = 0;
        qk.delete(); qu.delete();
        model_reset();
        set_bm(3, 3, 3, 3);
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check_eq("midrst_init_known", ifk.AlphaMetric, exp_known_bm3);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            set_bm(rand_bm(), rand_bm(), rand_bm(), rand_bm());
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0, int'($urandom_range(0, 1)),
                 $urandom_range(0, 9) < 7);
        end
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
